// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drainer for the async FIFO. It pulls words out of the FIFO read
// port (empty flag plus combinational read data) into a small ring buffer.
// It then re-presents them as a registered valid/ready stream. It lives
// entirely in the FIFO read clock domain.
//
// Parameters
//   data_t        word type, same as the FIFO's word type
//   BUF_DEPTH     ring buffer entries (power of two, >= 2)
//
// Ports
//   clk_i         read-domain clock, rising edge
//   rst_ni        asynchronous active-low reset
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO read data, valid whenever fifo_empty_i is low
//   fifo_rd_o     FIFO read enable; the FIFO pops at the edge where it is high
//   flush_i       synchronous discard of all buffered words
//   m_valid_o     stream valid (registered)
//   m_ready_i     stream ready
//   m_data_o      stream data (registered)
//   count_o       buffer occupancy
//   beats_o       completed stream handshakes, modulo 2^32
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter type data_t    = logic [7:0],
    parameter int  BUF_DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           fifo_empty_i,
    input  data_t                          fifo_data_i,
    output logic                           fifo_rd_o,
    input  logic                           flush_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output data_t                          m_data_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count_o,
    output logic [31:0]                    beats_o
);

    localparam int            CW       = $clog2(BUF_DEPTH + 1);
    localparam int            IW       = $clog2(BUF_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    data_t         mem_q [BUF_DEPTH];
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [31:0]   beats_q, beats_d;
    logic          push;
    logic          pop;

    // The read enable depends only on the FIFO flag, the registered full
    // flag and flush. Stream ready never reaches it combinationally. As a
    // result, a full buffer stalls the FIFO for one cycle after a pop.
    // At BUF_DEPTH=2 this still sustains one word per cycle.
    assign fifo_rd_o = !fifo_empty_i && !full_q && !flush_i;
    assign push      = fifo_rd_o;
    assign pop       = m_valid_o && m_ready_i;

    assign m_valid_o = (count_q != '0);
    assign m_data_o  = mem_q[rd_idx_q];
    assign count_o   = count_q;
    assign beats_o   = beats_q;

    // Flush clears indices and occupancy. A handshake taken in the same
    // cycle has already been seen downstream, so it still counts as a beat.
    // Index wrap relies on BUF_DEPTH being a power of two.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        beats_d  = pop ? beats_q + 32'd1 : beats_q;
        if (flush_i) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
            if (pop) begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            beats_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            full_q   <= full_d;
            beats_q  <= beats_d;
        end
    end

    // Entries are cleared on reset so that m_data_o reads zero while idle.
    // Push already excludes flush through fifo_rd_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_idx_q] <= fifo_data_i;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream (BUF_DEPTH=2, 8-bit words). The bench
// drives inputs on the falling clock edge. It samples registered outputs
// on that same falling edge, before changing any input. It samples the
// combinational read enable 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    logic        clk_i;
    logic        rst_ni;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_rd_o;
    logic        flush_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [7:0]  m_data_o;
    logic [1:0]  count_o;
    logic [31:0] beats_o;

    int checks = 0;
    int passes = 0;

    logic [7:0] w;
    logic [7:0] expOut;
    logic       hs;
    logic       rd;

    fifo_rd_stream #(
        .data_t    (logic [7:0]),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .count_o      (count_o),
        .beats_o      (beats_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (count_o !== 2'd0) $display("[TB] FAIL reset_count: got %0d want 0", count_o); else passes++;
        checks++; if (m_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", m_valid_o); else passes++;
        checks++; if (beats_o !== 32'd0) $display("[TB] FAIL reset_beats: got %0d want 0", beats_o); else passes++;
        checks++; if (m_data_o !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", m_data_o); else passes++;
        checks++; if (fifo_rd_o !== 1'b0) $display("[TB] FAIL reset_rd: got %0b want 0", fifo_rd_o); else passes++;
        // Load one word, then pull reset in the middle of the low phase.
        @(negedge clk_i);
        fifo_data_i  = 8'h5A;
        fifo_empty_i = 1'b0;
        @(negedge clk_i);
        fifo_empty_i = 1'b1;
        checks++; if (m_valid_o !== 1'b1) $display("[TB] FAIL prereset_valid: got %0b want 1", m_valid_o); else passes++;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0) $display("[TB] FAIL async_reset_valid: got %0b want 0", m_valid_o); else passes++;
        checks++; if (count_o !== 2'd0) $display("[TB] FAIL async_reset_count: got %0d want 0", count_o); else passes++;
        checks++; if (m_data_o !== 8'h00) $display("[TB] FAIL async_reset_data: got %h want 00", m_data_o); else passes++;
        checks++; if (fifo_rd_o !== 1'b0) $display("[TB] FAIL async_reset_rd: got %0b want 0", fifo_rd_o); else passes++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk_i);
        fifo_data_i  = 8'hA5;
        fifo_empty_i = 1'b0;
        m_ready_i    = 1'b1;
        #1;
        checks++; if (fifo_rd_o !== 1'b1) $display("[TB] FAIL single_rd: got %0b want 1", fifo_rd_o); else passes++;
        @(negedge clk_i);
        fifo_empty_i = 1'b1;
        checks++; if (m_valid_o !== 1'b1) $display("[TB] FAIL single_valid: got %0b want 1", m_valid_o); else passes++;
        checks++; if (m_data_o !== 8'hA5) $display("[TB] FAIL single_data: got %h want a5", m_data_o); else passes++;
        @(negedge clk_i);
        checks++; if (beats_o !== 32'd1) $display("[TB] FAIL single_beats: got %0d want 1", beats_o); else passes++;
        checks++; if (count_o !== 2'd0) $display("[TB] FAIL single_count: got %0d want 0", count_o); else passes++;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            if (k > 0) begin
                checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== 8'(k - 1))
                    $display("[TB] FAIL stream_word%0d: got valid=%0b data=%h want valid=1 data=%h", k - 1, m_valid_o, m_data_o, 8'(k - 1));
                else passes++;
            end
            fifo_data_i  = 8'(k);
            fifo_empty_i = 1'b0;
            m_ready_i    = 1'b1;
        end
        @(negedge clk_i);
        fifo_empty_i = 1'b1;
        checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h0F) $display("[TB] FAIL stream_last: got valid=%0b data=%h want valid=1 data=0f", m_valid_o, m_data_o); else passes++;
        @(negedge clk_i);
        checks++; if (beats_o !== 32'd17) $display("[TB] FAIL stream_beats: got %0d want 17", beats_o); else passes++;
        checks++; if (m_valid_o !== 1'b0) $display("[TB] FAIL stream_idle: got %0b want 0", m_valid_o); else passes++;
    endtask

    task automatic test_backpressure();
        w         = 8'h10;
        m_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            fifo_data_i  = w;
            fifo_empty_i = 1'b0;
            #1;
            checks++; if (fifo_rd_o !== 1'b1) $display("[TB] FAIL bp_fill_rd%0d: got %0b want 1", c, fifo_rd_o); else passes++;
            w = w + 8'd1;
        end
        @(negedge clk_i);
        fifo_data_i = w;
        #1;
        checks++; if (count_o !== 2'd2) $display("[TB] FAIL bp_count: got %0d want 2", count_o); else passes++;
        checks++; if (fifo_rd_o !== 1'b0) $display("[TB] FAIL bp_rd_stall: got %0b want 0", fifo_rd_o); else passes++;
        checks++; if (m_data_o !== 8'h10) $display("[TB] FAIL bp_data: got %h want 10", m_data_o); else passes++;
        @(negedge clk_i);
        checks++; if (m_data_o !== 8'h10) $display("[TB] FAIL bp_hold: got %h want 10", m_data_o); else passes++;
        m_ready_i = 1'b1;
        #1;
        checks++; if (fifo_rd_o !== 1'b0) $display("[TB] FAIL bp_rd_cycleM: got %0b want 0", fifo_rd_o); else passes++;
        @(negedge clk_i);
        checks++; if (count_o !== 2'd1 || m_data_o !== 8'h11) $display("[TB] FAIL bp_release: got count=%0d data=%h want count=1 data=11", count_o, m_data_o); else passes++;
        #1;
        checks++; if (fifo_rd_o !== 1'b1) $display("[TB] FAIL bp_rd_resume: got %0b want 1", fifo_rd_o); else passes++;
        expOut = 8'h11;
        for (int c = 0; c < 30 && expOut != 8'h18; c++) begin
            hs = m_valid_o && m_ready_i;
            rd = fifo_rd_o;
            @(negedge clk_i);
            if (hs) expOut = expOut + 8'd1;
            if (rd) w = w + 8'd1;
            if (m_valid_o) begin
                checks++; if (m_data_o !== expOut) $display("[TB] FAIL bp_order: got %h want %h", m_data_o, expOut); else passes++;
            end
            fifo_data_i  = w;
            fifo_empty_i = (w > 8'h17);
            #1;
        end
        checks++; if (expOut !== 8'h18) $display("[TB] FAIL bp_complete: got next=%h want 18", expOut); else passes++;
        checks++; if (beats_o !== 32'd25) $display("[TB] FAIL bp_beats: got %0d want 25", beats_o); else passes++;
    endtask

    task automatic test_flush();
        @(negedge clk_i);
        m_ready_i    = 1'b0;
        fifo_data_i  = 8'h20;
        fifo_empty_i = 1'b0;
        @(negedge clk_i);
        fifo_data_i  = 8'h21;
        @(negedge clk_i);
        fifo_data_i  = 8'h22;
        checks++; if (count_o !== 2'd2 || m_data_o !== 8'h20) $display("[TB] FAIL flush_pre: got count=%0d data=%h want count=2 data=20", count_o, m_data_o); else passes++;
        flush_i = 1'b1;
        #1;
        checks++; if (fifo_rd_o !== 1'b0) $display("[TB] FAIL flush_rd: got %0b want 0", fifo_rd_o); else passes++;
        @(negedge clk_i);
        flush_i = 1'b0;
        checks++; if (count_o !== 2'd0) $display("[TB] FAIL flush_count: got %0d want 0", count_o); else passes++;
        checks++; if (m_valid_o !== 1'b0) $display("[TB] FAIL flush_valid: got %0b want 0", m_valid_o); else passes++;
        checks++; if (beats_o !== 32'd25) $display("[TB] FAIL flush_beats: got %0d want 25", beats_o); else passes++;
        #1;
        checks++; if (fifo_rd_o !== 1'b1) $display("[TB] FAIL flush_resume_rd: got %0b want 1", fifo_rd_o); else passes++;
        m_ready_i = 1'b1;
        @(negedge clk_i);
        fifo_empty_i = 1'b1;
        checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h22) $display("[TB] FAIL flush_next: got valid=%0b data=%h want valid=1 data=22", m_valid_o, m_data_o); else passes++;
        @(negedge clk_i);
        checks++; if (beats_o !== 32'd26) $display("[TB] FAIL flush_after_beats: got %0d want 26", beats_o); else passes++;
    endtask

    task automatic test_wrap();
        @(negedge clk_i);
        force dut.beats_q = 32'hFFFF_FFFE;
        #1;
        release dut.beats_q;
        // Three handshakes carry the counter across the 32-bit boundary.
        w      = 8'h30;
        expOut = 8'h30;
        @(negedge clk_i);
        fifo_data_i  = w;
        fifo_empty_i = 1'b0;
        m_ready_i    = 1'b1;
        #1;
        for (int c = 0; c < 20 && expOut != 8'h33; c++) begin
            hs = m_valid_o && m_ready_i;
            rd = fifo_rd_o;
            @(negedge clk_i);
            if (hs) expOut = expOut + 8'd1;
            if (rd) w = w + 8'd1;
            if (m_valid_o) begin
                checks++; if (m_data_o !== expOut) $display("[TB] FAIL wrap_order: got %h want %h", m_data_o, expOut); else passes++;
            end
            fifo_data_i  = w;
            fifo_empty_i = (w > 8'h32);
            #1;
        end
        checks++; if (expOut !== 8'h33) $display("[TB] FAIL wrap_complete: got next=%h want 33", expOut); else passes++;
        checks++; if (beats_o !== 32'h0000_0001) $display("[TB] FAIL wrap_beats: got %h want 00000001", beats_o); else passes++;
        // Toggling ready walks the ring indices around several times.
        w      = 8'h40;
        expOut = 8'h40;
        @(negedge clk_i);
        fifo_data_i  = w;
        fifo_empty_i = 1'b0;
        #1;
        for (int c = 0; c < 40 && expOut != 8'h46; c++) begin
            hs = m_valid_o && m_ready_i;
            rd = fifo_rd_o;
            @(negedge clk_i);
            if (hs) expOut = expOut + 8'd1;
            if (rd) w = w + 8'd1;
            if (m_valid_o) begin
                checks++; if (m_data_o !== expOut) $display("[TB] FAIL ring_order: got %h want %h", m_data_o, expOut); else passes++;
            end
            fifo_data_i  = w;
            fifo_empty_i = (w > 8'h45);
            m_ready_i    = c[0];
            #1;
        end
        checks++; if (expOut !== 8'h46) $display("[TB] FAIL ring_complete: got next=%h want 46", expOut); else passes++;
        checks++; if (beats_o !== 32'd7) $display("[TB] FAIL ring_beats: got %0d want 7", beats_o); else passes++;
        checks++; if (count_o !== 2'd0) $display("[TB] FAIL ring_count: got %0d want 0", count_o); else passes++;
    endtask

    initial begin
        rst_ni       = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 8'h00;
        flush_i      = 1'b0;
        m_ready_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Single-clock read-side drainer for the async FIFO. It issues read enables against the FIFO read port (empty flag plus combinational read data) and re-presents the words as a registered valid/ready stream through a small output buffer. It sits in the read clock domain, between the FIFO's `r_en_i`/`r_empty_o`/`r_data_o` and downstream logic. Status outputs report buffer occupancy and a running count of delivered beats.

## Interface
- `data_t`, default `logic [7:0]`: word type, matching the FIFO's `data_t`.
- `BUF_DEPTH`, default 2: output buffer entries; power of two, ≥2.
- `clk_i` in 1: read-domain clock; all logic on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `fifo_empty_i` in 1: FIFO empty flag (`r_empty_o`).
- `fifo_data_i` in `data_t`: FIFO read data (`r_data_o`); valid combinationally whenever `fifo_empty_i`=0.
- `fifo_rd_o` out 1: FIFO read enable (`r_en_i`); the pointer advances at the clock edge where it is 1.
- `flush_i` in 1: synchronous discard of buffered words. FIFO contents are untouched.
- `m_valid_o` out 1: stream valid, registered.
- `m_ready_i` in 1: stream ready.
- `m_data_o` out `data_t`: stream data, registered.
- `count_o` out `$clog2(BUF_DEPTH+1)`: buffer occupancy.
- `beats_o` out 32: number of completed stream handshakes, modulo 2^32.

## Operation
- Storage is a ring buffer of `BUF_DEPTH` entries with write index, read index and occupancy register `count_q`.
- `full_q` = (`count_q`==`BUF_DEPTH`), derived from registered state only.
- `fifo_rd_o` = `!fifo_empty_i && !full_q && !flush_i`.
  - This is purely combinational from those three signals.
  - There is no combinational path from `m_ready_i` to `fifo_rd_o`.
- Push: when `fifo_rd_o`=1, `fifo_data_i` is written to `buf[wr_idx]` and `wr_idx` increments, wrapping modulo `BUF_DEPTH`.
- Pop: when `m_valid_o && m_ready_i`, `rd_idx` increments, wrapping, and `beats_o` increments, wrapping from 0xFFFF_FFFF to 0.
- Occupancy update per cycle:
  - Push and pop together: `count_q` unchanged.
  - Push only: +1.
  - Pop only: −1.
- `m_valid_o` = (`count_q`!=0). `m_data_o` = `buf[rd_idx]`.
  - Both come from registers only.
  - While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` stays stable.
- Flush, when `flush_i`=1 at an edge:
  - `count_q`, `wr_idx` and `rd_idx` become 0.
  - No push occurs.
  - A handshake in the same cycle still counts in `beats_o`.
  - Flush takes precedence over push and pop for storage state.
- Reset values:
  - `count_o`=0, `m_valid_o`=0, `beats_o`=0.
  - Indices are 0.
  - Buffer entries are 0, so `m_data_o`=0.
  - `fifo_rd_o` is 0 only if `fifo_empty_i`=1. The FIFO read-side reset must hold it empty.
- Reset mid-operation: all buffered words are lost immediately (asynchronous). The FIFO is not read during reset.

## Timing
- FIFO-to-stream latency:
  - `fifo_empty_i` falls in cycle N with buffer not full, so the push happens at edge N.
  - `m_valid_o`=1 with that word from cycle N+1.
- Throughput: one word per cycle sustained while the FIFO is non-empty and `m_ready_i`=1. With `BUF_DEPTH`=2, no bubbles at steady state.
- Backpressure:
  - With `m_ready_i`=0, the buffer fills. After `BUF_DEPTH` pushes, `fifo_rd_o` drops in the next cycle.
  - When `m_ready_i` rises in cycle M, `count` drops at edge M and `fifo_rd_o` reasserts in M+1.
- Data order is strictly FIFO order: no loss, no duplication.
- Flush asserted in cycle F: `m_valid_o`=0 and `count_o`=0 from F+1. Reading resumes in F+1 if the FIFO is non-empty.

## Test plan
- Reset: assert `rst_ni`=0 asynchronously mid-clock with `fifo_empty_i`=1 → all outputs zero at once; `fifo_rd_o`=0.
- Single word: `fifo_data_i`=0xA5, `fifo_empty_i` low for one cycle, `m_ready_i`=1 → `fifo_rd_o` high that cycle; next cycle `m_valid_o`=1, `m_data_o`=0xA5; one cycle later `beats_o`=1 and `count_o`=0.
- Stream: 16 words 0x00..0x0F with FIFO always non-empty and `m_ready_i`=1 → in-order output, one per cycle, `beats_o`=16, no bubbles.
- Backpressure: `m_ready_i`=0 while words 0x10.. are available → two pushes, `count_o`=2, `fifo_rd_o`=0, `m_data_o`=0x10 held. Then `m_ready_i`=1 → 0x10, 0x11, 0x12... delivered in order with no loss or duplication.
- Flush: `count_o`=2 holding 0x20/0x21, pulse `flush_i` with `m_ready_i`=0 → next cycle `count_o`=0, `m_valid_o`=0, `beats_o` unchanged. The next FIFO word (0x22) is then delivered.
- Wrap: preload `beats_o` near 0xFFFF_FFFE via a long run (or force), then run 3 handshakes → `beats_o`=0x0000_0001. Buffer indices wrap with no data corruption across more than 2×`BUF_DEPTH` transfers.
